// File: rtl/wimax_pkg.sv
// Shared WiMAX PRBS constants, burst state encoding and LFSR helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package wimax_pkg;

   localparam int IV_W   = 15;
   localparam int TAP_LO = 13;
   localparam int TAP_HI = 14;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } burst_state_t;

   // Feedback of 1 + x^14 + x^15 taken from the current register contents.
   function automatic logic prbs_fb(input logic [IV_W-1:0] s);
      return s[TAP_LO] ^ s[TAP_HI];
   endfunction

   // One LFSR step: shift left and insert the feedback bit at the bottom.
   function automatic logic [IV_W-1:0] prbs_shift(input logic [IV_W-1:0] s);
      return {s[IV_W-2:0], prbs_fb(s)};
   endfunction

endpackage

// File: rtl/derandomizer_if.sv
// Bit-serial derandomizer bus: input bits, burst control and output bits.
// Latency: none (wiring only).
// Backpressure: none; the data stream is valid-only.
interface derandomizer_if #(
   parameter int LEN_W = 16
);
   import wimax_pkg::*;

   logic             in_bits;
   logic             in_valid;
   logic [IV_W-1:0]  rand_iv;
   logic [LEN_W-1:0] burst_len;
   logic             reload;
   logic             out_bits;
   logic             out_valid;
   logic             out_last;
   logic             busy;
   logic             err_noiv;

   modport master (
      output in_bits, in_valid, rand_iv, burst_len, reload,
      input  out_bits, out_valid, out_last, busy, err_noiv
   );

   modport slave (
      input  in_bits, in_valid, rand_iv, burst_len, reload,
      output out_bits, out_valid, out_last, busy, err_noiv
   );

endinterface

// File: rtl/wimax_prbs15.sv
// 15-bit 802.16 PRBS register with seed load, advance and feedback output.
// Latency: fb is combinational; the register updates on the next edge.
// Backpressure: none; advance only when the caller consumes a bit.
module wimax_prbs15
   import wimax_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [IV_W-1:0] seed,
   input  logic            adv,
   output logic            fb
);

   logic [IV_W-1:0] s;
   logic [IV_W-1:0] base;

   // A load in the same cycle as an advance takes its feedback from the seed,
   // so the first bit of a burst can arrive together with the reload.
   assign base = load ? seed : s;
   assign fb   = prbs_fb(base);

   // LFSR register: load the seed, step it, or hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s <= '0;
      end else if (load || adv) begin
         s <= adv ? prbs_shift(base) : base;
      end
   end

endmodule

// File: rtl/derandomizer.sv
// Receive-side WiMAX derandomizer: XOR bits with the per-burst PRBS, count and flag burst end.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; one bit per cycle, input gaps pass through as output gaps.
module derandomizer
   import wimax_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic           clk,
   input  logic           reset,
   derandomizer_if.slave  bus
);

   burst_state_t     state, state_nxt;
   logic [LEN_W-1:0] count, count_nxt;
   logic             prbs_load, prbs_adv, fb;
   logic             emit, emit_last, err_set;
   logic             out_bits_q, out_valid_q, out_last_q, err_q;

   wimax_prbs15 u_prbs (
      .clk   (clk),
      .reset (reset),
      .load  (prbs_load),
      .seed  (bus.rand_iv),
      .adv   (prbs_adv),
      .fb    (fb)
   );

   // Next-state and per-bit decisions; reload always wins over a running burst.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      prbs_load = 1'b0;
      prbs_adv  = 1'b0;
      emit      = 1'b0;
      emit_last = 1'b0;
      err_set   = 1'b0;
      if (bus.reload) begin
         prbs_load = 1'b1;
         count_nxt = bus.burst_len;
         state_nxt = (bus.burst_len != '0) ? RUN : IDLE;
         if (bus.in_valid) begin
            if (bus.burst_len == '0) begin
               err_set = 1'b1;
            end else begin
               prbs_adv  = 1'b1;
               emit      = 1'b1;
               count_nxt = bus.burst_len - 1'b1;
               if (bus.burst_len == LEN_W'(1)) begin
                  emit_last = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
      end else if (bus.in_valid) begin
         if (state == RUN) begin
            prbs_adv  = 1'b1;
            emit      = 1'b1;
            count_nxt = count - 1'b1;
            if (count == LEN_W'(1)) begin
               emit_last = 1'b1;
               state_nxt = IDLE;
            end
         end else begin
            err_set = 1'b1;
         end
      end
   end

   // State and remaining-bit counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // Registered outputs; err_noiv is sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_bits_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_bits_q  <= emit & (bus.in_bits ^ fb);
         out_valid_q <= emit;
         out_last_q  <= emit_last;
         err_q       <= err_q | err_set;
      end
   end

   assign bus.out_bits  = out_bits_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.err_noiv  = err_q;
   assign bus.busy      = (state == RUN);

endmodule

// File: tb/tb_derandomizer.sv
// Scoreboard bench for derandomizer: directed bursts, expected bits queued at issue.
// Latency: expects each accepted bit one cycle later.
// Backpressure: none exercised; the design has none.
module tb_derandomizer;
   import wimax_pkg::*;

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   derandomizer_if #(.LEN_W(16)) bus ();

   derandomizer #(.LEN_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented output bit must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && bus.out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got bit %0b with empty scoreboard at %0t", bus.out_bits, $time);
         end else begin
            e = sb.pop_front();
            check("out_bits", {31'd0, bus.out_bits}, {31'd0, e.b});
            check("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc(input logic rl, input logic [14:0] iv, input logic [15:0] len,
                      input logic v, input logic b);
      @(negedge clk);
      bus.reload    = rl;
      bus.rand_iv   = iv;
      bus.burst_len = len;
      bus.in_valid  = v;
      bus.in_bits   = b;
   endtask

   task automatic idle();
      cyc(1'b0, 15'h0, 16'd0, 1'b0, 1'b0);
   endtask

   task automatic push(input logic b, input logic l);
      sb.push_back(exp_t'({b, l}));
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      check("drain", sb.size(), 0);
   endtask

   function automatic logic [14:0] gen_rand_iv(input logic [3:0] bsid, input logic [3:0] uiuc,
                                               input logic [3:0] frame_num);
      return {bsid, 2'b11, uiuc, 1'b1, frame_num};
   endfunction

   // Transmit-side reference randomizer, MSB first.
   function automatic logic [63:0] scramble(input logic [63:0] d, input logic [14:0] iv);
      logic [14:0] s;
      logic [63:0] r;
      logic        f;
      s = iv;
      r = '0;
      for (int i = 63; i >= 0; i--) begin
         f    = s[13] ^ s[14];
         r[i] = d[i] ^ f;
         s    = {s[13:0], f};
      end
      return r;
   endfunction

   initial begin
      logic [63:0] vec, rnd;
      logic [14:0] iv;
      logic [7:0]  g_in, g_exp;

      reset         = 1'b1;
      bus.reload    = 1'b0;
      bus.rand_iv   = '0;
      bus.burst_len = '0;
      bus.in_valid  = 1'b0;
      bus.in_bits   = 1'b0;
      #12;
      check("rst_out_valid", {31'd0, bus.out_valid}, 0);
      check("rst_out_bits",  {31'd0, bus.out_bits},  0);
      check("rst_out_last",  {31'd0, bus.out_last},  0);
      check("rst_busy",      {31'd0, bus.busy},      0);
      check("rst_err_noiv",  {31'd0, bus.err_noiv},  0);
      @(negedge clk);
      reset = 1'b0;

      // Reset asserted mid-burst clears outputs immediately.
      cyc(1'b1, 15'h2000, 16'd16, 1'b0, 1'b0);
      cyc(1'b0, 15'h0, 16'd0, 1'b1, 1'b0);
      after_edge();
      check("mid_pre_valid", {31'd0, bus.out_valid}, 1);
      check("mid_pre_bits",  {31'd0, bus.out_bits},  1);
      check("mid_pre_busy",  {31'd0, bus.busy},      1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, bus.out_valid}, 0);
      check("mid_rst_bits",  {31'd0, bus.out_bits},  0);
      check("mid_rst_busy",  {31'd0, bus.busy},      0);
      idle();
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b0, 15'h0, 16'd0, 1'b1, 1'b1);
      after_edge();
      check("idle_bit_err",   {31'd0, bus.err_noiv},  1);
      check("idle_bit_valid", {31'd0, bus.out_valid}, 0);
      idle();
      after_edge();
      check("err_sticky", {31'd0, bus.err_noiv}, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("err_cleared", {31'd0, bus.err_noiv}, 0);
      mon_en = 1'b1;

      // PRBS from IV 0x0001 over zero input: 13 zeros, then 1, 1, 0 (last).
      cyc(1'b1, 15'h0001, 16'd16, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         push((i == 13 || i == 14), (i == 15));
         cyc(1'b0, 15'h0, 16'd0, 1'b1, 1'b0);
      end
      after_edge();
      check("prbs_last", {31'd0, bus.out_last}, 1);
      check("prbs_busy", {31'd0, bus.busy},     0);
      idle();
      drain();

      // Gapped burst: IV 0x2000 gives fb 1,1,0,0,0,0,0,0.
      g_in  = 8'b1011_0010;
      g_exp = 8'b0111_0010;
      cyc(1'b1, 15'h2000, 16'd8, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         push(g_exp[i], (i == 0));
         cyc(1'b0, 15'h0, 16'd0, 1'b1, g_in[i]);
         idle();
         after_edge();
         check("gap_valid", {31'd0, bus.out_valid}, 0);
      end
      check("gap_busy_end", {31'd0, bus.busy}, 0);
      drain();

      // Single-bit burst coincident with reload: last on the bit, busy never rises.
      push(1'b1, 1'b1);
      cyc(1'b1, 15'h2000, 16'd1, 1'b1, 1'b0);
      after_edge();
      check("b2b_busy_len1", {31'd0, bus.busy}, 0);
      // Open a 4-bit burst, abort after 2 bits with a new IV and length 3.
      cyc(1'b1, 15'h0001, 16'd4, 1'b0, 1'b0);
      after_edge();
      check("b2b_busy_run", {31'd0, bus.busy}, 1);
      push(1'b0, 1'b0);
      cyc(1'b0, 15'h0, 16'd0, 1'b1, 1'b0);
      push(1'b0, 1'b0);
      cyc(1'b0, 15'h0, 16'd0, 1'b1, 1'b0);
      cyc(1'b1, 15'h2000, 16'd3, 1'b0, 1'b0);
      push(1'b1, 1'b0);
      cyc(1'b0, 15'h0, 16'd0, 1'b1, 1'b0);
      push(1'b1, 1'b0);
      cyc(1'b0, 15'h0, 16'd0, 1'b1, 1'b0);
      push(1'b0, 1'b1);
      cyc(1'b0, 15'h0, 16'd0, 1'b1, 1'b0);
      idle();
      drain();

      // Round trip of the 802.16 test vector head, first bit coincident with reload.
      vec = 64'h4529_C479_AD0F_5528;
      iv  = gen_rand_iv(4'h5, 4'h7, 4'h3);
      rnd = scramble(vec, iv);
      for (int i = 63; i >= 0; i--) begin
         push(vec[i], (i == 0));
         cyc((i == 63), iv, 16'd64, 1'b1, rnd[i]);
      end
      idle();
      after_edge();
      check("rt_busy_end", {31'd0, bus.busy}, 0);
      drain();

      // Zero-length burst with a coincident bit: dropped and flagged.
      check("zl_err_before", {31'd0, bus.err_noiv}, 0);
      cyc(1'b1, 15'h1234, 16'd0, 1'b1, 1'b1);
      after_edge();
      check("zl_valid", {31'd0, bus.out_valid}, 0);
      check("zl_err",   {31'd0, bus.err_noiv},  1);
      check("zl_busy",  {31'd0, bus.busy},      0);
      idle();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
